// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM path (generator, frequency divider, meter).
// Holds the default counter width, the default loss-of-signal timeout, the
// divider terminal count and the measurement FSM state encoding.
package pwm_pkg;

    // Default width of the period / high-time counters.
    localparam int unsigned CNT_W_DEF = 16;

    // Default number of cycles without a rising edge before declaring loss of signal.
    localparam logic [15:0] TIMEOUT_DEF = 16'd65535;

    // Terminal count of the frequency divider that feeds the PWM generator.
    localparam int unsigned DIV_CUENTA = 32050;

    // Measurement FSM: ESPERA = waiting to arm on a rising edge, MIDE = measuring.
    typedef enum logic [0:0] {
        ESPERA = 1'b0,
        MIDE   = 1'b1
    } estado_t;

endpackage

// File: rtl/sincronizador_flanco.sv
// Two-flop synchronizer for the asynchronous PWM line plus rising-edge detect.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset (clears all three flops)
//   linea : asynchronous PWM input
//   nivel : synchronized level (second synchronizer flop)
//   sube  : one-cycle pulse when the synchronized level goes 0 -> 1
module sincronizador_flanco
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic linea,
    output logic nivel,
    output logic sube
);

    logic s1_r;
    logic s2_r;
    logic prev_r;

    // Synchronizer chain s1 -> s2, then prev holds the previous synchronized level.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r   <= 1'b0;
            s2_r   <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            s1_r   <= linea;
            s2_r   <= s1_r;
            prev_r <= s2_r;
        end
    end

    assign nivel = s2_r;
    assign sube  = s2_r & ~prev_r;

endmodule

// File: rtl/medidor_pwm.sv
// PWM capture / measurement block.
// Measures, per PWM period, the full period and the high time in Clock_in
// cycles, reports each completed measurement with a one-cycle strobe and
// flags loss of signal when no rising edge arrives within TIMEOUT cycles.
// Ports:
//   Clock_in    : system clock (100 MHz)
//   Reset       : synchronous, active-high reset
//   pwm_in      : asynchronous PWM line to measure
//   periodo     : last measured period (0 after a timeout)
//   tiempo_alto : last measured high time (0 after a timeout)
//   med_valida  : one-cycle strobe, the three result outputs just updated
//   sin_senal   : loss of signal, cleared by the next valid measurement
//   nivel_fijo  : synchronized line level captured at the timeout
module medidor_pwm
    import pwm_pkg::*;
#(
    parameter int unsigned        CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0]   TIMEOUT = CNT_W'(TIMEOUT_DEF)
) (
    input  logic             Clock_in,
    input  logic             Reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] periodo,
    output logic [CNT_W-1:0] tiempo_alto,
    output logic             med_valida,
    output logic             sin_senal,
    output logic             nivel_fijo
);

    localparam logic [CNT_W-1:0] CNT_CERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_UNO  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic nivel_s;
    logic sube_s;

    estado_t          estado_r;
    estado_t          estado_sig_s;
    logic [CNT_W-1:0] cnt_per_r;
    logic [CNT_W-1:0] cnt_per_s;
    logic [CNT_W-1:0] cnt_alto_r;
    logic [CNT_W-1:0] cnt_alto_s;
    logic [CNT_W-1:0] periodo_r;
    logic [CNT_W-1:0] periodo_s;
    logic [CNT_W-1:0] alto_r;
    logic [CNT_W-1:0] alto_s;
    logic             valida_r;
    logic             valida_s;
    logic             sin_r;
    logic             sin_s;
    logic             nivel_fijo_r;
    logic             nivel_fijo_s;
    logic             timeout_s;

    sincronizador_flanco u_sinc (
        .clk   (Clock_in),
        .reset (Reset),
        .linea (pwm_in),
        .nivel (nivel_s),
        .sube  (sube_s)
    );

    // A rising edge in the same cycle as the timeout takes priority, so the
    // timeout condition is only the count match; sube is tested first below.
    assign timeout_s = (cnt_per_r == TIMEOUT);

    // State register.
    always_ff @(posedge Clock_in) begin
        if (Reset) begin
            estado_r <= ESPERA;
        end else begin
            estado_r <= estado_sig_s;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_sig_s = estado_r;
        case (estado_r)
            ESPERA: begin
                if (sube_s) begin
                    estado_sig_s = MIDE;
                end else begin
                    estado_sig_s = ESPERA;
                end
            end
            MIDE: begin
                if (sube_s) begin
                    estado_sig_s = MIDE;
                end else if (timeout_s) begin
                    estado_sig_s = ESPERA;
                end else begin
                    estado_sig_s = MIDE;
                end
            end
            default: begin
                estado_sig_s = ESPERA;
            end
        endcase
    end

    // Counter and result next values. The first edge after ESPERA only arms
    // the counters because the period in progress started before we saw it.
    always_comb begin
        cnt_per_s    = cnt_per_r;
        cnt_alto_s   = cnt_alto_r;
        periodo_s    = periodo_r;
        alto_s       = alto_r;
        valida_s     = 1'b0;
        sin_s        = sin_r;
        nivel_fijo_s = nivel_fijo_r;
        case (estado_r)
            ESPERA: begin
                if (sube_s) begin
                    cnt_per_s  = CNT_UNO;
                    cnt_alto_s = CNT_UNO;
                end else begin
                    cnt_per_s  = CNT_CERO;
                    cnt_alto_s = CNT_CERO;
                end
            end
            MIDE: begin
                if (sube_s) begin
                    // The edge cycle itself is counted as cycle 1 of the new period,
                    // so the count reached here equals the full period.
                    periodo_s  = cnt_per_r;
                    alto_s     = cnt_alto_r;
                    valida_s   = 1'b1;
                    sin_s      = 1'b0;
                    cnt_per_s  = CNT_UNO;
                    cnt_alto_s = CNT_UNO;
                end else if (timeout_s) begin
                    periodo_s    = CNT_CERO;
                    alto_s       = CNT_CERO;
                    valida_s     = 1'b1;
                    sin_s        = 1'b1;
                    nivel_fijo_s = nivel_s;
                    cnt_per_s    = CNT_CERO;
                    cnt_alto_s   = CNT_CERO;
                end else begin
                    if (cnt_per_r != CNT_MAX) begin
                        cnt_per_s = cnt_per_r + CNT_UNO;
                    end else begin
                        cnt_per_s = cnt_per_r;
                    end
                    if (nivel_s && (cnt_alto_r != CNT_MAX)) begin
                        cnt_alto_s = cnt_alto_r + CNT_UNO;
                    end else begin
                        cnt_alto_s = cnt_alto_r;
                    end
                end
            end
            default: begin
                cnt_per_s  = CNT_CERO;
                cnt_alto_s = CNT_CERO;
            end
        endcase
    end

    // Counter and output registers.
    always_ff @(posedge Clock_in) begin
        if (Reset) begin
            cnt_per_r    <= CNT_CERO;
            cnt_alto_r   <= CNT_CERO;
            periodo_r    <= CNT_CERO;
            alto_r       <= CNT_CERO;
            valida_r     <= 1'b0;
            sin_r        <= 1'b0;
            nivel_fijo_r <= 1'b0;
        end else begin
            cnt_per_r    <= cnt_per_s;
            cnt_alto_r   <= cnt_alto_s;
            periodo_r    <= periodo_s;
            alto_r       <= alto_s;
            valida_r     <= valida_s;
            sin_r        <= sin_s;
            nivel_fijo_r <= nivel_fijo_s;
        end
    end

    assign periodo     = periodo_r;
    assign tiempo_alto = alto_r;
    assign med_valida  = valida_r;
    assign sin_senal   = sin_r;
    assign nivel_fijo  = nivel_fijo_r;

endmodule

// File: tb/tb_medidor_pwm.sv
// Self-checking bench for medidor_pwm with TIMEOUT = 1000.
// Expected strobes are queued before the stimulus that causes them and are
// popped by a monitor whenever med_valida is seen high.
module tb_medidor_pwm;
    import pwm_pkg::*;

    localparam int unsigned      CW = 16;
    localparam logic [CW-1:0]    TO = 16'd1000;

    logic          Clock_in = 1'b0;
    logic          Reset;
    logic          pwm_in;
    logic [CW-1:0] periodo;
    logic [CW-1:0] tiempo_alto;
    logic          med_valida;
    logic          sin_senal;
    logic          nivel_fijo;

    typedef struct {
        logic [CW-1:0] per;
        logic [CW-1:0] alto;
        logic          sin;
        logic          nivel;
    } exp_t;

    typedef struct {
        int            p;
        int            h;
        int            n;
        logic [CW-1:0] e_per;
        logic [CW-1:0] e_alto;
    } vec_t;

    exp_t sb[$];
    exp_t e_mon;
    vec_t tabla[6];
    int   checks = 0;
    int   errors = 0;

    medidor_pwm #(
        .CNT_W   (CW),
        .TIMEOUT (TO)
    ) dut (
        .Clock_in    (Clock_in),
        .Reset       (Reset),
        .pwm_in      (pwm_in),
        .periodo     (periodo),
        .tiempo_alto (tiempo_alto),
        .med_valida  (med_valida),
        .sin_senal   (sin_senal),
        .nivel_fijo  (nivel_fijo)
    );

    always #5 Clock_in = ~Clock_in;

    task automatic comparar(input string nombre, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nombre, act, req, $time);
        end
    endtask

    task automatic push_med(input logic [CW-1:0] per, input logic [CW-1:0] alto);
        exp_t e;
        e.per = per; e.alto = alto; e.sin = 1'b0; e.nivel = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push_to(input logic nivel);
        exp_t e;
        e.per = 16'd0; e.alto = 16'd0; e.sin = 1'b1; e.nivel = nivel;
        sb.push_back(e);
    endtask

    // n periods of p cycles, high for the first h cycles; starts and ends on a negedge.
    task automatic drive(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            repeat (h) @(negedge Clock_in);
            pwm_in = 1'b0;
            repeat (p - h) @(negedge Clock_in);
        end
    endtask

    task automatic wait_empty(input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(negedge Clock_in);
            c++;
        end
        if (sb.size() != 0) begin
            comparar("pending strobes", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge Clock_in);
    endtask

    initial begin
        tabla[0] = '{100,  25,  5, 16'd100,  16'd25};
        tabla[1] = '{7,    3,   4, 16'd7,    16'd3};
        tabla[2] = '{2,    1,   6, 16'd2,    16'd1};
        tabla[3] = '{1000, 400, 3, 16'd1000, 16'd400};
        tabla[4] = '{10,   9,   3, 16'd10,   16'd9};
        tabla[5] = '{37,   1,   4, 16'd37,   16'd1};

        Reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge Clock_in);
        Reset = 1'b0;
        comparar("reset periodo", periodo, 0);
        comparar("reset tiempo_alto", tiempo_alto, 0);
        comparar("reset med_valida", med_valida, 0);
        comparar("reset sin_senal", sin_senal, 0);
        comparar("reset nivel_fijo", nivel_fijo, 0);

        // Monitor: every strobe must match the head of the scoreboard.
        fork
            forever begin
                @(negedge Clock_in);
                if (med_valida === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected strobe: periodo %0d tiempo_alto %0d sin_senal %0b, expected none (t=%0t)",
                                 periodo, tiempo_alto, sin_senal, $time);
                    end else begin
                        e_mon = sb.pop_front();
                        comparar("periodo", periodo, e_mon.per);
                        comparar("tiempo_alto", tiempo_alto, e_mon.alto);
                        comparar("sin_senal", sin_senal, e_mon.sin);
                        if (e_mon.sin) begin
                            comparar("nivel_fijo", nivel_fijo, e_mon.nivel);
                        end
                    end
                end
            end
        join_none

        // Table: first rise only arms, each later rise reports, then the line
        // stays low and a timeout with nivel_fijo=0 follows.
        for (int v = 0; v < 6; v++) begin
            for (int j = 1; j < tabla[v].n; j++) begin
                push_med(tabla[v].e_per, tabla[v].e_alto);
            end
            push_to(1'b0);
            drive(tabla[v].p, tabla[v].h, tabla[v].n);
            wait_empty(1500);
        end

        // Strobe latency: line high before edge k, strobe visible after edge k+2.
        drive(100, 25, 1);
        push_med(16'd100, 16'd25);
        push_to(1'b0);
        pwm_in = 1'b1;
        @(negedge Clock_in);
        comparar("latency after k", med_valida, 0);
        @(negedge Clock_in);
        comparar("latency after k+1", med_valida, 0);
        @(negedge Clock_in);
        comparar("latency after k+2", med_valida, 1);
        repeat (22) @(negedge Clock_in);
        pwm_in = 1'b0;
        repeat (75) @(negedge Clock_in);
        wait_empty(1500);

        // 2-cycle periods switching to 3-cycle periods.
        repeat (4) push_med(16'd2, 16'd1);
        repeat (2) push_med(16'd3, 16'd2);
        push_to(1'b0);
        drive(2, 1, 4);
        drive(3, 2, 3);
        wait_empty(1500);

        // Line stuck low after a single rise.
        push_to(1'b0);
        pwm_in = 1'b1;
        repeat (3) @(negedge Clock_in);
        pwm_in = 1'b0;
        wait_empty(1500);

        // Line stuck high after a single rise.
        push_to(1'b1);
        pwm_in = 1'b1;
        wait_empty(1500);
        comparar("stuck high sin_senal", sin_senal, 1);
        pwm_in = 1'b0;
        repeat (10) @(negedge Clock_in);

        // Reset mid-period: outputs cleared, next rise only re-arms.
        push_med(16'd50, 16'd20);
        push_med(16'd50, 16'd20);
        push_med(16'd50, 16'd20);
        drive(50, 20, 3);
        pwm_in = 1'b1;
        repeat (20) @(negedge Clock_in);
        pwm_in = 1'b0;
        repeat (10) @(negedge Clock_in);
        wait_empty(100);
        Reset = 1'b1;
        @(negedge Clock_in);
        Reset = 1'b0;
        comparar("mid reset periodo", periodo, 0);
        comparar("mid reset tiempo_alto", tiempo_alto, 0);
        comparar("mid reset med_valida", med_valida, 0);
        comparar("mid reset sin_senal", sin_senal, 0);
        comparar("mid reset nivel_fijo", nivel_fijo, 0);
        repeat (20) @(negedge Clock_in);
        push_med(16'd50, 16'd20);
        push_to(1'b0);
        drive(50, 20, 2);
        wait_empty(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
